// File: rtl/writeback_unit_pkg.sv
// Package wb_pkg: shared encodings for the write-back stage.
//   - WB_SRC_*     : register-file write value select (in_wb_src)
//   - LB..LWU      : RV load funct3 encodings understood by load_align
//   - wb_state_e   : write-back FSM state encoding
package wb_pkg;

  // Write-back value source select
  localparam logic [1:0] WB_SRC_ALU  = 2'b00;
  localparam logic [1:0] WB_SRC_PC4  = 2'b01;
  localparam logic [1:0] WB_SRC_LOAD = 2'b10;
  localparam logic [1:0] WB_SRC_CSR  = 2'b11;

  // Load funct3 encodings (RV base ISA)
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LD  = 3'b011;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] LWU = 3'b110;

  // FSM states: IDLE accepts new work, WAIT_MEM holds a captured load
  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_WAIT_MEM = 1'b1
  } wb_state_e;

endpackage

// File: rtl/writeback_unit_if.sv
// Interface writeback_unit_if: MEM -> WB instruction bus plus the data-memory load response.
//   master : MEM stage / memory side (drives in_* fields and mem_rsp_*, observes in_ready)
//   slave  : writeback_unit (observes in_* and mem_rsp_*, drives in_ready)
interface writeback_unit_if #(
  parameter int XLEN  = 32,
  parameter int RF_AW = 5
);

  logic             in_valid;
  logic             in_ready;
  logic             in_rf_wb;
  logic [1:0]       in_wb_src;
  logic             in_pc_src;
  logic [RF_AW-1:0] in_rd;
  logic [2:0]       in_funct3;
  logic [XLEN-1:0]  in_alu_result;
  logic [XLEN-1:0]  in_pc_plus4;
  logic [XLEN-1:0]  in_csr_data;
  logic [XLEN-1:0]  in_target_pc;
  logic             mem_rsp_valid;
  logic [XLEN-1:0]  mem_rsp_data;

  modport master (
    output in_valid, in_rf_wb, in_wb_src, in_pc_src, in_rd, in_funct3,
           in_alu_result, in_pc_plus4, in_csr_data, in_target_pc,
           mem_rsp_valid, mem_rsp_data,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_rf_wb, in_wb_src, in_pc_src, in_rd, in_funct3,
           in_alu_result, in_pc_plus4, in_csr_data, in_target_pc,
           mem_rsp_valid, mem_rsp_data,
    output in_ready
  );

endinterface

// File: rtl/writeback_unit_load_align.sv
// load_align: combinational load formatter.
//   funct3   in  : load size/sign encoding
//   offset   in  : byte offset of the access inside the raw word/dword
//   raw_data in  : aligned word/dword returned by data memory
//   data     out : extracted, sign/zero-extended load value
//   misalign out : access not naturally aligned, or funct3 not a load legal for XLEN
module load_align
  import wb_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int OFF_W = $clog2(XLEN/8)
) (
  input  logic [2:0]       funct3,
  input  logic [OFF_W-1:0] offset,
  input  logic [XLEN-1:0]  raw_data,
  output logic [XLEN-1:0]  data,
  output logic             misalign
);

  // Bring the addressed byte down to bit 0 so every size extracts from the LSBs
  logic [XLEN-1:0] shifted_s;
  assign shifted_s = raw_data >> {offset, 3'b000};

  // Size/sign selection and natural-alignment check
  always_comb begin
    data     = shifted_s;
    misalign = 1'b0;
    case (funct3)
      LB:  data = XLEN'($signed(shifted_s[7:0]));
      LBU: data = XLEN'(shifted_s[7:0]);
      LH: begin
        data     = XLEN'($signed(shifted_s[15:0]));
        misalign = offset[0];
      end
      LHU: begin
        data     = XLEN'(shifted_s[15:0]);
        misalign = offset[0];
      end
      LW: begin
        // On RV32 a word already fills the register, so no extension happens
        data     = XLEN'($signed(shifted_s[31:0]));
        misalign = (offset[1:0] != 2'b00);
      end
      LWU: begin
        data = XLEN'(shifted_s[31:0]);
        if (XLEN == 64) begin
          misalign = (offset[1:0] != 2'b00);
        end else begin
          misalign = 1'b1;
        end
      end
      LD: begin
        data = shifted_s;
        if (XLEN == 64) begin
          misalign = (offset != {OFF_W{1'b0}});
        end else begin
          misalign = 1'b1;
        end
      end
      default: begin
        data     = shifted_s;
        misalign = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// writeback_unit: final RV pipeline stage.
//   clk, rst      : clock and synchronous active-high reset
//   flush         : kill the instruction being accepted or the pending load
//   bus (slave)   : MEM -> WB instruction fields, in_valid/in_ready handshake, load response
//   wb_*          : registered register-file write, redirect and misalign outputs
//   stall_cycles  : saturating count of cycles spent waiting for load data
// Non-loads and loads whose response arrives with them retire one cycle after acceptance.
// Other loads are captured and retired one cycle after their response arrives.
module writeback_unit
  import wb_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int RF_AW = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  writeback_unit_if.slave  bus,
  output logic             wb_valid,
  output logic             wb_rf_we,
  output logic [RF_AW-1:0] wb_rd,
  output logic [XLEN-1:0]  wb_data,
  output logic             wb_pc_src,
  output logic [XLEN-1:0]  wb_target_pc,
  output logic             wb_misalign,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int OFF_W = $clog2(XLEN/8);

  wb_state_e state_r, state_nxt_s;

  logic in_ready_s, retire_s, capture_s, in_is_load_s;

  // Pending-load capture registers
  logic             cap_rf_wb_r, cap_pc_src_r;
  logic [1:0]       cap_wb_src_r;
  logic [RF_AW-1:0] cap_rd_r;
  logic [2:0]       cap_funct3_r;
  logic [XLEN-1:0]  cap_alu_r, cap_pc4_r, cap_csr_r, cap_target_r;

  // Fields of the instruction retiring this cycle (live or captured)
  logic             sel_rf_wb_s, sel_pc_src_s;
  logic [1:0]       sel_wb_src_s;
  logic [RF_AW-1:0] sel_rd_s;
  logic [2:0]       sel_funct3_s;
  logic [XLEN-1:0]  sel_alu_s, sel_pc4_s, sel_csr_s, sel_target_s;

  logic [XLEN-1:0]  ld_data_s, wr_data_s;
  logic             ld_misalign_s, misalign_s;

  // Output registers
  logic             wb_valid_r, wb_rf_we_r, wb_pc_src_r, wb_misalign_r;
  logic [RF_AW-1:0] wb_rd_r;
  logic [XLEN-1:0]  wb_data_r, wb_target_r;
  logic [CNT_W-1:0] stall_r;

  assign in_is_load_s = (bus.in_wb_src == WB_SRC_LOAD);

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (capture_s) begin
          state_nxt_s = ST_WAIT_MEM;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT_MEM: begin
        // A flush drops the pending load even if its response shows up now
        if (flush || bus.mem_rsp_valid) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WAIT_MEM;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM outputs: handshake, retire and capture strobes
  always_comb begin
    in_ready_s = 1'b0;
    retire_s   = 1'b0;
    capture_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        in_ready_s = !rst && !flush;
        if (bus.in_valid && in_ready_s) begin
          if (!in_is_load_s || bus.mem_rsp_valid) begin
            retire_s = 1'b1;
          end else begin
            capture_s = 1'b1;
          end
        end else begin
          retire_s = 1'b0;
        end
      end
      ST_WAIT_MEM: begin
        if (!rst && !flush && bus.mem_rsp_valid) begin
          retire_s = 1'b1;
        end else begin
          retire_s = 1'b0;
        end
      end
      default: begin
        in_ready_s = 1'b0;
      end
    endcase
  end

  assign bus.in_ready = in_ready_s;

  // Capture a load that must wait for its response
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_rf_wb_r  <= 1'b0;
      cap_pc_src_r <= 1'b0;
      cap_wb_src_r <= 2'b00;
      cap_rd_r     <= '0;
      cap_funct3_r <= 3'b000;
      cap_alu_r    <= '0;
      cap_pc4_r    <= '0;
      cap_csr_r    <= '0;
      cap_target_r <= '0;
    end else if (capture_s) begin
      cap_rf_wb_r  <= bus.in_rf_wb;
      cap_pc_src_r <= bus.in_pc_src;
      cap_wb_src_r <= bus.in_wb_src;
      cap_rd_r     <= bus.in_rd;
      cap_funct3_r <= bus.in_funct3;
      cap_alu_r    <= bus.in_alu_result;
      cap_pc4_r    <= bus.in_pc_plus4;
      cap_csr_r    <= bus.in_csr_data;
      cap_target_r <= bus.in_target_pc;
    end
  end

  // Pick the captured instruction while waiting, otherwise the live one
  always_comb begin
    if (state_r == ST_WAIT_MEM) begin
      sel_rf_wb_s  = cap_rf_wb_r;
      sel_pc_src_s = cap_pc_src_r;
      sel_wb_src_s = cap_wb_src_r;
      sel_rd_s     = cap_rd_r;
      sel_funct3_s = cap_funct3_r;
      sel_alu_s    = cap_alu_r;
      sel_pc4_s    = cap_pc4_r;
      sel_csr_s    = cap_csr_r;
      sel_target_s = cap_target_r;
    end else begin
      sel_rf_wb_s  = bus.in_rf_wb;
      sel_pc_src_s = bus.in_pc_src;
      sel_wb_src_s = bus.in_wb_src;
      sel_rd_s     = bus.in_rd;
      sel_funct3_s = bus.in_funct3;
      sel_alu_s    = bus.in_alu_result;
      sel_pc4_s    = bus.in_pc_plus4;
      sel_csr_s    = bus.in_csr_data;
      sel_target_s = bus.in_target_pc;
    end
  end

  load_align #(
    .XLEN  (XLEN),
    .OFF_W (OFF_W)
  ) u_load_align (
    .funct3   (sel_funct3_s),
    .offset   (sel_alu_s[OFF_W-1:0]),
    .raw_data (bus.mem_rsp_data),
    .data     (ld_data_s),
    .misalign (ld_misalign_s)
  );

  // Register-file write value select; misalign only matters for loads
  always_comb begin
    wr_data_s  = sel_alu_s;
    misalign_s = 1'b0;
    case (sel_wb_src_s)
      WB_SRC_ALU: wr_data_s = sel_alu_s;
      WB_SRC_PC4: wr_data_s = sel_pc4_s;
      WB_SRC_LOAD: begin
        wr_data_s  = ld_data_s;
        misalign_s = ld_misalign_s;
      end
      WB_SRC_CSR: wr_data_s = sel_csr_s;
      default:    wr_data_s = sel_alu_s;
    endcase
  end

  // Registered write-back outputs; strobes drop when nothing retires
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid_r    <= 1'b0;
      wb_rf_we_r    <= 1'b0;
      wb_pc_src_r   <= 1'b0;
      wb_misalign_r <= 1'b0;
      wb_rd_r       <= '0;
      wb_data_r     <= '0;
      wb_target_r   <= '0;
    end else if (retire_s) begin
      wb_valid_r    <= 1'b1;
      wb_rf_we_r    <= sel_rf_wb_s && (sel_rd_s != '0) && !misalign_s;
      wb_pc_src_r   <= sel_pc_src_s;
      wb_misalign_r <= misalign_s;
      wb_rd_r       <= sel_rd_s;
      wb_data_r     <= wr_data_s;
      wb_target_r   <= sel_target_s;
    end else begin
      wb_valid_r  <= 1'b0;
      wb_rf_we_r  <= 1'b0;
      wb_pc_src_r <= 1'b0;
    end
  end

  // Saturating count of WAIT_MEM cycles without a response
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_r <= '0;
    end else if ((state_r == ST_WAIT_MEM) && !bus.mem_rsp_valid && (stall_r != {CNT_W{1'b1}})) begin
      stall_r <= stall_r + CNT_W'(1);
    end
  end

  assign wb_valid     = wb_valid_r;
  assign wb_rf_we     = wb_rf_we_r;
  assign wb_rd        = wb_rd_r;
  assign wb_data      = wb_data_r;
  assign wb_pc_src    = wb_pc_src_r;
  assign wb_target_pc = wb_target_r;
  assign wb_misalign  = wb_misalign_r;
  assign stall_cycles = stall_r;

endmodule

// File: tb/tb_writeback_unit.sv
module tb_writeback_unit;
  import wb_pkg::*;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        wb_valid, wb_rf_we, wb_pc_src, wb_misalign;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, wb_target_pc;
  logic [2:0]  stall_cycles;

  writeback_unit_if #(.XLEN(32), .RF_AW(5)) bus ();

  writeback_unit #(.XLEN(32), .RF_AW(5), .CNT_W(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .bus          (bus),
    .wb_valid     (wb_valid),
    .wb_rf_we     (wb_rf_we),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .wb_pc_src    (wb_pc_src),
    .wb_target_pc (wb_target_pc),
    .wb_misalign  (wb_misalign),
    .stall_cycles (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rf_we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        pc_src;
    logic [31:0] target;
    logic        mis;
  } exp_t;

  typedef struct {
    logic        rf_wb;
    logic [1:0]  src;
    logic        pc_src;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [31:0] alu;
    logic [31:0] pc4;
    logic [31:0] csr;
    logic [31:0] tgt;
    logic [31:0] rsp;
    logic        e_we;
    logic [31:0] e_data;
    logic        e_mis;
  } vec_t;

  exp_t sb[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic vec_t mk(logic rf_wb, logic [1:0] src, logic pc_src, logic [4:0] rd,
                              logic [2:0] f3, logic [31:0] alu, logic [31:0] pc4,
                              logic [31:0] csr, logic [31:0] tgt, logic [31:0] rsp,
                              logic e_we, logic [31:0] e_data, logic e_mis);
    vec_t v;
    v.rf_wb = rf_wb; v.src = src; v.pc_src = pc_src; v.rd = rd; v.f3 = f3;
    v.alu = alu; v.pc4 = pc4; v.csr = csr; v.tgt = tgt; v.rsp = rsp;
    v.e_we = e_we; v.e_data = e_data; v.e_mis = e_mis;
    return v;
  endfunction

  task automatic push_exp(input logic we, input logic [4:0] rd, input logic [31:0] data,
                          input logic pc_src, input logic [31:0] tgt, input logic mis);
    exp_t e;
    e.rf_we = we; e.rd = rd; e.data = data; e.pc_src = pc_src; e.target = tgt; e.mis = mis;
    sb.push_back(e);
  endtask

  // Advance to the next falling edge and compare any retired instruction with the scoreboard
  task automatic step();
    exp_t e;
    @(negedge clk);
    if (wb_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_wb_valid", {63'd0, wb_valid}, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("wb_rf_we", {63'd0, wb_rf_we}, {63'd0, e.rf_we});
        chk("wb_rd", {59'd0, wb_rd}, {59'd0, e.rd});
        if (!e.mis) chk("wb_data", {32'd0, wb_data}, {32'd0, e.data});
        chk("wb_pc_src", {63'd0, wb_pc_src}, {63'd0, e.pc_src});
        if (e.pc_src) chk("wb_target_pc", {32'd0, wb_target_pc}, {32'd0, e.target});
        chk("wb_misalign", {63'd0, wb_misalign}, {63'd0, e.mis});
      end
    end else begin
      chk("idle_rf_we", {63'd0, wb_rf_we}, 64'd0);
      chk("idle_pc_src", {63'd0, wb_pc_src}, 64'd0);
    end
  endtask

  task automatic idle_inputs();
    bus.in_valid      = 1'b0;
    bus.in_rf_wb      = 1'b0;
    bus.in_wb_src     = WB_SRC_ALU;
    bus.in_pc_src     = 1'b0;
    bus.in_rd         = 5'd0;
    bus.in_funct3     = 3'd0;
    bus.in_alu_result = 32'd0;
    bus.in_pc_plus4   = 32'd0;
    bus.in_csr_data   = 32'd0;
    bus.in_target_pc  = 32'd0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = 32'd0;
    flush             = 1'b0;
  endtask

  // Present a load on the bus without a response (it must wait)
  task automatic drive_load(input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] addr);
    bus.in_valid      = 1'b1;
    bus.in_rf_wb      = 1'b1;
    bus.in_wb_src     = WB_SRC_LOAD;
    bus.in_pc_src     = 1'b0;
    bus.in_rd         = rd;
    bus.in_funct3     = f3;
    bus.in_alu_result = addr;
    bus.mem_rsp_valid = 1'b0;
  endtask

  vec_t vt[18];

  initial begin
    vt[0]  = mk(1'b1, WB_SRC_ALU,  1'b0, 5'd5,  LB,     32'h1234, 32'd0, 32'd0, 32'd0, 32'd0,       1'b1, 32'h1234,     1'b0);
    vt[1]  = mk(1'b1, WB_SRC_LOAD, 1'b0, 5'd7,  LB,     32'h1003, 32'd0, 32'd0, 32'd0, 32'h80FFFFFF, 1'b1, 32'hFFFFFF80, 1'b0);
    vt[2]  = mk(1'b1, WB_SRC_LOAD, 1'b0, 5'd7,  LBU,    32'h1003, 32'd0, 32'd0, 32'd0, 32'h80FFFFFF, 1'b1, 32'h00000080, 1'b0);
    vt[3]  = mk(1'b1, WB_SRC_LOAD, 1'b0, 5'd8,  LH,     32'h0101, 32'd0, 32'd0, 32'd0, 32'h12345678, 1'b0, 32'd0,        1'b1);
    vt[4]  = mk(1'b1, WB_SRC_PC4,  1'b1, 5'd0,  LB,     32'h1000, 32'h104, 32'd0, 32'h200, 32'd0,   1'b0, 32'h104,      1'b0);
    vt[5]  = mk(1'b1, WB_SRC_CSR,  1'b0, 5'd3,  LB,     32'h0,    32'd0, 32'hDEADBEEF, 32'd0, 32'd0, 1'b1, 32'hDEADBEEF, 1'b0);
    vt[6]  = mk(1'b1, WB_SRC_LOAD, 1'b0, 5'd9,  LH,     32'h0102, 32'd0, 32'd0, 32'd0, 32'h80017FFF, 1'b1, 32'hFFFF8001, 1'b0);
    vt[7]  = mk(1'b1, WB_SRC_LOAD, 1'b0, 5'd9,  LHU,    32'h0102, 32'd0, 32'd0, 32'd0, 32'h80017FFF, 1'b1, 32'h00008001, 1'b0);
    vt[8]  = mk(1'b1, WB_SRC_LOAD, 1'b0, 5'd10, LW,     32'h0104, 32'd0, 32'd0, 32'd0, 32'hCAFEF00D, 1'b1, 32'hCAFEF00D, 1'b0);
    vt[9]  = mk(1'b1, WB_SRC_LOAD, 1'b0, 5'd10, LW,     32'h0106, 32'd0, 32'd0, 32'd0, 32'hCAFEF00D, 1'b0, 32'd0,        1'b1);
    vt[10] = mk(1'b1, WB_SRC_LOAD, 1'b0, 5'd11, LD,     32'h0100, 32'd0, 32'd0, 32'd0, 32'h11111111, 1'b0, 32'd0,        1'b1);
    vt[11] = mk(1'b1, WB_SRC_LOAD, 1'b0, 5'd1,  LB,     32'h1001, 32'd0, 32'd0, 32'd0, 32'h00008000, 1'b1, 32'hFFFFFF80, 1'b0);
    vt[12] = mk(1'b1, WB_SRC_LOAD, 1'b0, 5'd2,  LB,     32'h1000, 32'd0, 32'd0, 32'd0, 32'h0000007F, 1'b1, 32'h0000007F, 1'b0);
    vt[13] = mk(1'b1, WB_SRC_ALU,  1'b0, 5'd0,  LB,     32'h0055, 32'd0, 32'd0, 32'd0, 32'd0,       1'b0, 32'h00000055, 1'b0);
    vt[14] = mk(1'b0, WB_SRC_ALU,  1'b0, 5'd9,  LB,     32'h0077, 32'd0, 32'd0, 32'd0, 32'd0,       1'b0, 32'h00000077, 1'b0);
    vt[15] = mk(1'b1, WB_SRC_LOAD, 1'b0, 5'd4,  LWU,    32'h0100, 32'd0, 32'd0, 32'd0, 32'h22222222, 1'b0, 32'd0,        1'b1);
    vt[16] = mk(1'b1, WB_SRC_LOAD, 1'b0, 5'd4,  3'b111, 32'h0100, 32'd0, 32'd0, 32'd0, 32'h33333333, 1'b0, 32'd0,        1'b1);
    vt[17] = mk(1'b0, WB_SRC_ALU,  1'b1, 5'd6,  LB,     32'h0009, 32'd0, 32'd0, 32'h3000, 32'd0,    1'b0, 32'h00000009, 1'b0);

    // Reset state
    rst = 1'b1;
    idle_inputs();
    repeat (3) step();
    chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
    chk("rst_wb_valid", {63'd0, wb_valid}, 64'd0);
    chk("rst_wb_data", {32'd0, wb_data}, 64'd0);
    chk("rst_wb_target", {32'd0, wb_target_pc}, 64'd0);
    chk("rst_stall", {61'd0, stall_cycles}, 64'd0);
    rst = 1'b0;
    step();
    chk("post_rst_in_ready", {63'd0, bus.in_ready}, 64'd1);

    // Table-driven single-cycle retirements, back to back
    for (int i = 0; i < 18; i++) begin
      bus.in_valid      = 1'b1;
      bus.in_rf_wb      = vt[i].rf_wb;
      bus.in_wb_src     = vt[i].src;
      bus.in_pc_src     = vt[i].pc_src;
      bus.in_rd         = vt[i].rd;
      bus.in_funct3     = vt[i].f3;
      bus.in_alu_result = vt[i].alu;
      bus.in_pc_plus4   = vt[i].pc4;
      bus.in_csr_data   = vt[i].csr;
      bus.in_target_pc  = vt[i].tgt;
      bus.mem_rsp_valid = (vt[i].src == WB_SRC_LOAD);
      bus.mem_rsp_data  = vt[i].rsp;
      #1;
      chk("tbl_in_ready", {63'd0, bus.in_ready}, 64'd1);
      push_exp(vt[i].e_we, vt[i].rd, vt[i].e_data, vt[i].pc_src, vt[i].tgt, vt[i].e_mis);
      step();
    end
    idle_inputs();
    step();
    chk("tbl_drained", 64'(sb.size()), 64'd0);

    // LW with a response three waiting cycles later
    drive_load(LW, 5'd10, 32'h100);
    #1;
    chk("lw_accept_ready", {63'd0, bus.in_ready}, 64'd1);
    push_exp(1'b1, 5'd10, 32'h11223344, 1'b0, 32'd0, 1'b0);
    step();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("wait_in_ready", {63'd0, bus.in_ready}, 64'd0);
      step();
    end
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 32'h11223344;
    #1;
    chk("rsp_cycle_in_ready", {63'd0, bus.in_ready}, 64'd0);
    step();
    idle_inputs();
    chk("lw_retired", 64'(sb.size()), 64'd0);
    chk("stall_after_lw", {61'd0, stall_cycles}, 64'd3);
    chk("ready_after_lw", {63'd0, bus.in_ready}, 64'd1);

    // Flush of a pending load coinciding with its response
    drive_load(LW, 5'd11, 32'h140);
    step();
    idle_inputs();
    flush             = 1'b1;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 32'hA5A5A5A5;
    step();
    idle_inputs();
    #1;
    chk("flush_ready_next", {63'd0, bus.in_ready}, 64'd1);
    step();
    step();
    chk("flush_stall", {61'd0, stall_cycles}, 64'd3);

    // Flush in IDLE blocks acceptance; stray responses in IDLE are ignored
    bus.in_valid      = 1'b1;
    bus.in_rf_wb      = 1'b1;
    bus.in_rd         = 5'd12;
    bus.in_alu_result = 32'hBEEF;
    flush             = 1'b1;
    #1;
    chk("flush_idle_ready", {63'd0, bus.in_ready}, 64'd0);
    step();
    idle_inputs();
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 32'h12121212;
    step();
    step();
    idle_inputs();
    step();

    // Captured fields must be used while live inputs change (LH, rd=0)
    drive_load(LH, 5'd0, 32'h102);
    push_exp(1'b0, 5'd0, 32'hFFFFF00F, 1'b0, 32'd0, 1'b0);
    step();
    idle_inputs();
    bus.in_funct3     = LBU;
    bus.in_rd         = 5'd31;
    bus.in_alu_result = 32'h0;
    step();
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 32'hF00F0000;
    step();
    idle_inputs();
    chk("capture_retired", 64'(sb.size()), 64'd0);
    chk("stall_after_lh", {61'd0, stall_cycles}, 64'd4);

    // Stall counter saturation
    drive_load(LW, 5'd12, 32'h200);
    push_exp(1'b1, 5'd12, 32'h0BADF00D, 1'b0, 32'd0, 1'b0);
    step();
    idle_inputs();
    repeat (5) step();
    chk("stall_saturated", {61'd0, stall_cycles}, 64'd7);
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 32'h0BADF00D;
    step();
    idle_inputs();
    chk("sat_retired", 64'(sb.size()), 64'd0);
    chk("stall_held", {61'd0, stall_cycles}, 64'd7);

    // Reset while a load is pending
    drive_load(LW, 5'd13, 32'h300);
    step();
    idle_inputs();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 32'h77777777;
    step();
    idle_inputs();
    step();
    chk("rst_mid_stall", {61'd0, stall_cycles}, 64'd0);
    chk("rst_mid_data", {32'd0, wb_data}, 64'd0);
    chk("rst_mid_rd", {59'd0, wb_rd}, 64'd0);
    chk("rst_mid_ready", {63'd0, bus.in_ready}, 64'd1);
    chk("final_drained", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
